// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared decode definitions for the decode/issue scoreboard: opcode encodings,
// architectural register aliases and the per-opcode read/write predicates.
package decode_issue_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SW    = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LW    = 5'b01000;
    localparam logic [OPC_W-1:0] OP_BNE   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_BLT   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_JR    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SETX  = 5'b10101;
    localparam logic [OPC_W-1:0] OP_BEX   = 5'b10110;

    localparam logic [REG_W-1:0] REG_ZERO    = 5'd0;
    localparam logic [REG_W-1:0] REG_RSTATUS = 5'd30;
    localparam logic [REG_W-1:0] REG_RA      = 5'd31;

    // True when the opcode consumes the reg_S1 operand.
    function automatic logic reads_s1(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: reads_s1 = 1'b1;
            default:                                          reads_s1 = 1'b0;
        endcase
    endfunction

    // True when the opcode consumes the reg_S2 operand.
    function automatic logic reads_s2(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_SW, OP_BNE, OP_BLT, OP_JR: reads_s2 = 1'b1;
            default:                                reads_s2 = 1'b0;
        endcase
    endfunction

    // True when the opcode writes the decoder's reg_D field.
    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW: writes_rd = 1'b1;
            default:                  writes_rd = 1'b0;
        endcase
    endfunction

    // Effective destination register; r0 means "no architectural write".
    function automatic logic [REG_W-1:0] eff_dest(input logic [OPC_W-1:0] op,
                                                   input logic [REG_W-1:0] reg_d);
        if (writes_rd(op)) begin
            eff_dest = reg_d;
        end else begin
            case (op)
                OP_JAL:  eff_dest = REG_RA;
                OP_SETX: eff_dest = REG_RSTATUS;
                default: eff_dest = REG_ZERO;
            endcase
        end
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard_scoreboard_counter.sv
// One register's in-flight writer count. Increments and up to two decrements
// net out in a single cycle; the result saturates at zero and at full scale.

module scoreboard_counter_checker (
    input logic clock,
    input logic reset,
    input logic underflow
);

    a_no_underflow: assert property (@(posedge clock) disable iff (reset) !underflow);

endmodule

module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] count
);

    localparam int MAX_I = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] next_s;
    logic [CNT_W:0]   up_s;
    logic [CNT_W:0]   dec_s;
    logic [CNT_W:0]   diff_s;
    logic             underflow_s;

    // Net the increment against both decrements, clamping at both ends.
    always_comb begin
        up_s        = {1'b0, count_r} + {{CNT_W{1'b0}}, inc};
        dec_s       = {{CNT_W{1'b0}}, dec_a} + {{CNT_W{1'b0}}, dec_b};
        underflow_s = (up_s < dec_s);
        diff_s      = up_s - dec_s;
        if (underflow_s) begin
            next_s = {CNT_W{1'b0}};
        end else if (diff_s > MAX_I[CNT_W:0]) begin
            next_s = MAX_I[CNT_W-1:0];
        end else begin
            next_s = diff_s[CNT_W-1:0];
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign count = count_r;

    scoreboard_counter_checker u_chk (
        .clock     (clock),
        .reset     (reset),
        .underflow (underflow_s)
    );

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Decode-stage issue control: hazard detection against a per-register
// pending-write scoreboard and the D/X pipeline latch.
module decode_issue_scoreboard
    import decode_issue_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fd_valid,
    input  logic [31:0] fd_instruction,
    input  logic [4:0]  reg_S1,
    input  logic [4:0]  reg_S2,
    input  logic [4:0]  reg_D,
    input  logic        ex_hold,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    output logic        stall,
    output logic        issue,
    output logic        dx_valid,
    output logic [31:0] dx_instruction,
    output logic [4:0]  dx_dest
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] counts_s [NUM_REGS];

    logic [OPC_W-1:0] op_s;
    logic [REG_W-1:0] dest_s;
    logic             busy_s1_s;
    logic             busy_s2_s;
    logic             busy_bex_s;
    logic             sat_s;
    logic             stall_s;
    logic             issue_s;

    logic             dx_valid_r;
    logic [31:0]      dx_instruction_r;
    logic [REG_W-1:0] dx_dest_r;

    assign counts_s[0] = CNT_ZERO;

    // Hazard detection and issue decision for the instruction in decode.
    always_comb begin
        op_s       = fd_instruction[31:27];
        dest_s     = eff_dest(op_s, reg_D);
        busy_s1_s  = reads_s1(op_s) && (reg_S1 != REG_ZERO) && (counts_s[reg_S1] != CNT_ZERO);
        busy_s2_s  = reads_s2(op_s) && (reg_S2 != REG_ZERO) && (counts_s[reg_S2] != CNT_ZERO);
        busy_bex_s = (op_s == OP_BEX) && (counts_s[REG_RSTATUS] != CNT_ZERO);
        sat_s      = (dest_s != REG_ZERO) && (counts_s[dest_s] == CNT_MAX);
        if (fd_valid && !flush &&
            (busy_s1_s || busy_s2_s || busy_bex_s || sat_s || (ex_hold && dx_valid_r))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        issue_s = fd_valid && !flush && !stall_s;
    end

    // D/X latch: flush beats hold, hold beats issue, otherwise insert a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx_valid_r       <= 1'b0;
            dx_instruction_r <= 32'h0000_0000;
            dx_dest_r        <= REG_ZERO;
        end else if (flush) begin
            dx_valid_r <= 1'b0;
        end else if (ex_hold && dx_valid_r) begin
            dx_valid_r <= dx_valid_r;
        end else if (issue_s) begin
            dx_valid_r       <= 1'b1;
            dx_instruction_r <= fd_instruction;
            dx_dest_r        <= dest_s;
        end else begin
            dx_valid_r <= 1'b0;
        end
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        logic inc_s;
        logic dec_wb_s;
        logic dec_fl_s;

        assign inc_s    = issue_s && (dest_s == REG_W'(g));
        assign dec_wb_s = wb_valid && (wb_reg == REG_W'(g));
        assign dec_fl_s = flush && dx_valid_r && (dx_dest_r == REG_W'(g));

        scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (inc_s),
            .dec_a (dec_wb_s),
            .dec_b (dec_fl_s),
            .count (counts_s[g])
        );
    end

    assign stall          = stall_s;
    assign issue          = issue_s;
    assign dx_valid       = dx_valid_r;
    assign dx_instruction = dx_instruction_r;
    assign dx_dest        = dx_dest_r;

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed bench for decode_issue_scoreboard with hand-computed expectations.
module tb_decode_issue_scoreboard;

    localparam logic [4:0] T_RTYPE = 5'b00000;
    localparam logic [4:0] T_ADDI  = 5'b00101;
    localparam logic [4:0] T_LW    = 5'b01000;
    localparam logic [4:0] T_JAL   = 5'b00011;
    localparam logic [4:0] T_SETX  = 5'b10101;
    localparam logic [4:0] T_BEX   = 5'b10110;

    logic        clock;
    logic        reset;
    logic        fd_valid;
    logic [31:0] fd_instruction;
    logic [4:0]  reg_S1;
    logic [4:0]  reg_S2;
    logic [4:0]  reg_D;
    logic        ex_hold;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        stall;
    logic        issue;
    logic        dx_valid;
    logic [31:0] dx_instruction;
    logic [4:0]  dx_dest;

    int vecs;
    int miscompares;

    decode_issue_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .fd_valid       (fd_valid),
        .fd_instruction (fd_instruction),
        .reg_S1         (reg_S1),
        .reg_S2         (reg_S2),
        .reg_D          (reg_D),
        .ex_hold        (ex_hold),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .stall          (stall),
        .issue          (issue),
        .dx_valid       (dx_valid),
        .dx_instruction (dx_instruction),
        .dx_dest        (dx_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fd_valid = 1'b0; fd_instruction = 32'h0; reg_S1 = 5'd0; reg_S2 = 5'd0; reg_D = 5'd0;
        ex_hold = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0;
    endtask

    task automatic present(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [11:0] tag, output logic [31:0] instr);
        instr = {op, d, s1, s2, tag};
        fd_valid = 1'b1; fd_instruction = instr; reg_D = d; reg_S1 = s1; reg_S2 = s2;
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        idle();
        reset = 1'b1;
        #3;
        vecs++; if (dx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dx_valid: got %b want 0", dx_valid); end
        vecs++; if (dx_instruction !== 32'h0) begin miscompares++; $display("FAIL reset_dx_instr: got %h want 0", dx_instruction); end
        vecs++; if (dx_dest !== 5'd0) begin miscompares++; $display("FAIL reset_dx_dest: got %0d want 0", dx_dest); end
        vecs++; if (stall !== 1'b0 || issue !== 1'b0) begin miscompares++; $display("FAIL reset_idle_ctl: got stall=%b issue=%b want 0/0", stall, issue); end
        present(T_ADDI, 5'd3, 5'd0, 5'd0, 12'h003, ins);
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL reset_comb_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b0 || dut.counts_s[3] !== 2'd0) begin miscompares++; $display("FAIL reset_hold_state: got valid=%b cnt3=%0d want 0/0", dx_valid, dut.counts_s[3]); end
        idle();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_raw();
        logic [31:0] ia, ib;
        tick();
        present(T_ADDI, 5'd5, 5'd1, 5'd0, 12'h007, ia);
        #1;
        vecs++; if (issue !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("FAIL raw_addi_issue: got issue=%b stall=%b want 1/0", issue, stall); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd5 || dx_instruction !== ia) begin miscompares++; $display("FAIL raw_addi_dx: got v=%b d=%0d i=%h want 1/5/%h", dx_valid, dx_dest, dx_instruction, ia); end
        vecs++; if (dut.counts_s[5] !== 2'd1) begin miscompares++; $display("FAIL raw_cnt5_up: got %0d want 1", dut.counts_s[5]); end
        present(T_RTYPE, 5'd6, 5'd5, 5'd2, 12'h020, ib);
        #1;
        vecs++; if (stall !== 1'b1 || issue !== 1'b0) begin miscompares++; $display("FAIL raw_add_stall: got stall=%b issue=%b want 1/0", stall, issue); end
        tick();
        vecs++; if (dx_valid !== 1'b0 || dx_instruction !== ia) begin miscompares++; $display("FAIL raw_bubble: got v=%b i=%h want 0/%h", dx_valid, dx_instruction, ia); end
        wb_valid = 1'b1; wb_reg = 5'd5;
        #1;
        vecs++; if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_no_bypass: got stall=%b want 1", stall); end
        tick();
        wb_valid = 1'b0;
        vecs++; if (dut.counts_s[5] !== 2'd0) begin miscompares++; $display("FAIL raw_cnt5_down: got %0d want 0", dut.counts_s[5]); end
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL raw_add_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd6 || dx_instruction !== ib) begin miscompares++; $display("FAIL raw_add_dx: got v=%b d=%0d i=%h want 1/6/%h", dx_valid, dx_dest, dx_instruction, ib); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd6;
        tick();
        idle();
        vecs++; if (dut.counts_s[6] !== 2'd0) begin miscompares++; $display("FAIL raw_cnt6_clean: got %0d want 0", dut.counts_s[6]); end
    endtask

    task automatic test_saturation();
        logic [31:0] ins, id;
        for (int k = 0; k < 3; k++) begin
            present(T_ADDI, 5'd7, 5'd0, 5'd0, 12'(k), ins);
            #1;
            vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL sat_fill_issue%0d: got %b want 1", k, issue); end
            tick();
        end
        present(T_ADDI, 5'd7, 5'd0, 5'd0, 12'h003, id);
        #1;
        vecs++; if (dut.counts_s[7] !== 2'd3) begin miscompares++; $display("FAIL sat_cnt_full: got %0d want 3", dut.counts_s[7]); end
        vecs++; if (stall !== 1'b1 || issue !== 1'b0) begin miscompares++; $display("FAIL sat_stall: got stall=%b issue=%b want 1/0", stall, issue); end
        tick();
        wb_valid = 1'b1; wb_reg = 5'd7;
        #1;
        vecs++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sat_stall_during_wb: got %b want 1", stall); end
        tick();
        wb_valid = 1'b0;
        vecs++; if (dut.counts_s[7] !== 2'd2) begin miscompares++; $display("FAIL sat_cnt_after_wb: got %0d want 2", dut.counts_s[7]); end
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL sat_fourth_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dut.counts_s[7] !== 2'd3 || dx_instruction !== id) begin miscompares++; $display("FAIL sat_refill: got cnt=%0d i=%h want 3/%h", dut.counts_s[7], dx_instruction, id); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd7;
        tick(); tick(); tick();
        idle();
        vecs++; if (dut.counts_s[7] !== 2'd0) begin miscompares++; $display("FAIL sat_clean: got %0d want 0", dut.counts_s[7]); end
    endtask

    task automatic test_net();
        logic [31:0] ins;
        present(T_ADDI, 5'd9, 5'd0, 5'd0, 12'h090, ins);
        tick();
        vecs++; if (dut.counts_s[9] !== 2'd1) begin miscompares++; $display("FAIL net_cnt_pre: got %0d want 1", dut.counts_s[9]); end
        present(T_ADDI, 5'd9, 5'd0, 5'd0, 12'h091, ins);
        wb_valid = 1'b1; wb_reg = 5'd9;
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL net_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dut.counts_s[9] !== 2'd1) begin miscompares++; $display("FAIL net_cnt_same: got %0d want 1", dut.counts_s[9]); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd9;
        tick();
        idle();
        vecs++; if (dut.counts_s[9] !== 2'd0) begin miscompares++; $display("FAIL net_clean: got %0d want 0", dut.counts_s[9]); end
    endtask

    task automatic test_flush();
        logic [31:0] il, id;
        present(T_LW, 5'd4, 5'd1, 5'd0, 12'h040, il);
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd4 || dut.counts_s[4] !== 2'd1) begin miscompares++; $display("FAIL flush_lw_dx: got v=%b d=%0d cnt=%0d want 1/4/1", dx_valid, dx_dest, dut.counts_s[4]); end
        present(T_RTYPE, 5'd8, 5'd4, 5'd0, 12'h080, id);
        flush = 1'b1;
        #1;
        vecs++; if (stall !== 1'b0 || issue !== 1'b0) begin miscompares++; $display("FAIL flush_squash_ctl: got stall=%b issue=%b want 0/0", stall, issue); end
        tick();
        flush = 1'b0;
        vecs++; if (dx_valid !== 1'b0 || dut.counts_s[4] !== 2'd0) begin miscompares++; $display("FAIL flush_dx_cnt: got v=%b cnt4=%0d want 0/0", dx_valid, dut.counts_s[4]); end
        #1;
        vecs++; if (stall !== 1'b0 || issue !== 1'b1) begin miscompares++; $display("FAIL flush_dep_free: got stall=%b issue=%b want 0/1", stall, issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd8 || dut.counts_s[8] !== 2'd1) begin miscompares++; $display("FAIL flush_dep_dx: got v=%b d=%0d cnt=%0d want 1/8/1", dx_valid, dx_dest, dut.counts_s[8]); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd8;
        tick();
        idle();
    endtask

    task automatic test_hold();
        logic [31:0] ia, ib;
        tick();
        present(T_ADDI, 5'd10, 5'd0, 5'd0, 12'h0A0, ia);
        ex_hold = 1'b1;
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL hold_empty_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd10) begin miscompares++; $display("FAIL hold_first_dx: got v=%b d=%0d want 1/10", dx_valid, dx_dest); end
        present(T_ADDI, 5'd11, 5'd0, 5'd0, 12'h0B0, ib);
        #1;
        vecs++; if (stall !== 1'b1 || issue !== 1'b0) begin miscompares++; $display("FAIL hold_stall: got stall=%b issue=%b want 1/0", stall, issue); end
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++; if (dx_valid !== 1'b1 || dx_instruction !== ia || dx_dest !== 5'd10) begin miscompares++; $display("FAIL hold_frozen%0d: got v=%b i=%h d=%0d want 1/%h/10", k, dx_valid, dx_instruction, dx_dest, ia); end
        end
        vecs++; if (dut.counts_s[11] !== 2'd0) begin miscompares++; $display("FAIL hold_no_inc: got %0d want 0", dut.counts_s[11]); end
        flush = 1'b1;
        #1;
        vecs++; if (stall !== 1'b0 || issue !== 1'b0) begin miscompares++; $display("FAIL hold_flush_ctl: got stall=%b issue=%b want 0/0", stall, issue); end
        tick();
        vecs++; if (dx_valid !== 1'b0 || dut.counts_s[10] !== 2'd0) begin miscompares++; $display("FAIL hold_flush_dx: got v=%b cnt10=%0d want 0/0", dx_valid, dut.counts_s[10]); end
        flush = 1'b0; ex_hold = 1'b0;
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL hold_release_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_instruction !== ib || dut.counts_s[11] !== 2'd1) begin miscompares++; $display("FAIL hold_release_dx: got v=%b i=%h cnt=%0d want 1/%h/1", dx_valid, dx_instruction, dut.counts_s[11], ib); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd11;
        tick();
        idle();
    endtask

    task automatic test_special();
        logic [31:0] ins;
        present(T_SETX, 5'd3, 5'd0, 5'd0, 12'h5E0, ins);
        tick();
        vecs++; if (dx_dest !== 5'd30 || dut.counts_s[30] !== 2'd1 || dut.counts_s[3] !== 2'd0) begin miscompares++; $display("FAIL setx_dest: got d=%0d cnt30=%0d cnt3=%0d want 30/1/0", dx_dest, dut.counts_s[30], dut.counts_s[3]); end
        present(T_BEX, 5'd0, 5'd0, 5'd0, 12'hBE0, ins);
        #1;
        vecs++; if (stall !== 1'b1) begin miscompares++; $display("FAIL bex_stall: got %b want 1", stall); end
        wb_valid = 1'b1; wb_reg = 5'd30;
        tick();
        wb_valid = 1'b0;
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL bex_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd0) begin miscompares++; $display("FAIL bex_no_dest: got v=%b d=%0d want 1/0", dx_valid, dx_dest); end
        present(T_JAL, 5'd5, 5'd0, 5'd0, 12'hA10, ins);
        tick();
        vecs++; if (dx_dest !== 5'd31 || dut.counts_s[31] !== 2'd1 || dut.counts_s[5] !== 2'd0) begin miscompares++; $display("FAIL jal_dest: got d=%0d cnt31=%0d cnt5=%0d want 31/1/0", dx_dest, dut.counts_s[31], dut.counts_s[5]); end
        present(T_ADDI, 5'd20, 5'd0, 5'd31, 12'h200, ins);
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL unread_s2_issue: got %b want 1", issue); end
        tick();
        idle(); wb_valid = 1'b1; wb_reg = 5'd31;
        tick();
        wb_reg = 5'd20;
        tick();
        idle();
        vecs++; if (dut.counts_s[31] !== 2'd0 || dut.counts_s[20] !== 2'd0) begin miscompares++; $display("FAIL special_clean: got cnt31=%0d cnt20=%0d want 0/0", dut.counts_s[31], dut.counts_s[20]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic [4:0]  d;
        for (int k = 0; k < 3; k++) begin
            d = 5'(12 + k);
            present(T_ADDI, d, 5'd0, 5'd0, 12'(k), ins);
            #1;
            vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL b2b_issue%0d: got %b want 1", k, issue); end
            tick();
            vecs++; if (dx_valid !== 1'b1 || dx_dest !== d || dx_instruction !== ins) begin miscompares++; $display("FAIL b2b_dx%0d: got v=%b d=%0d i=%h want 1/%0d/%h", k, dx_valid, dx_dest, dx_instruction, d, ins); end
        end
        idle(); wb_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wb_reg = 5'(12 + k);
            tick();
        end
        idle();
        vecs++; if (dut.counts_s[12] !== 2'd0 || dut.counts_s[14] !== 2'd0) begin miscompares++; $display("FAIL b2b_clean: got cnt12=%0d cnt14=%0d want 0/0", dut.counts_s[12], dut.counts_s[14]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ins;
        present(T_ADDI, 5'd15, 5'd0, 5'd0, 12'h0F0, ins);
        tick();
        vecs++; if (dut.counts_s[15] !== 2'd1 || dx_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got cnt15=%0d v=%b want 1/1", dut.counts_s[15], dx_valid); end
        idle();
        #2;
        reset = 1'b1;
        #1;
        vecs++; if (dx_valid !== 1'b0 || dut.counts_s[15] !== 2'd0 || dx_instruction !== 32'h0) begin miscompares++; $display("FAIL rmid_async: got v=%b cnt15=%0d i=%h want 0/0/0", dx_valid, dut.counts_s[15], dx_instruction); end
        @(negedge clock);
        reset = 1'b0;
        present(T_ADDI, 5'd16, 5'd15, 5'd0, 12'h160, ins);
        #1;
        vecs++; if (issue !== 1'b1) begin miscompares++; $display("FAIL rmid_first_issue: got %b want 1", issue); end
        tick();
        vecs++; if (dx_valid !== 1'b1 || dx_dest !== 5'd16 || dut.counts_s[16] !== 2'd1) begin miscompares++; $display("FAIL rmid_first_dx: got v=%b d=%0d cnt=%0d want 1/16/1", dx_valid, dx_dest, dut.counts_s[16]); end
        idle(); wb_valid = 1'b1; wb_reg = 5'd16;
        tick();
        idle();
    endtask

    initial begin
        vecs = 0;
        miscompares = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_saturation();
        test_net();
        test_flush();
        test_hold();
        test_special();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
